// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants and types.
// Holds the NewHope modulus, its Montgomery inverse and radix, and the coefficient type.
package ntt_pkg;

  localparam int unsigned NEWHOPE_Q    = 12289;
  localparam int unsigned NEWHOPE_QINV = 12287;  // -Q^-1 mod 2^18
  localparam int unsigned MONT_R_BITS  = 18;

  typedef logic [15:0] coeff_t;

  localparam int unsigned COEFF_W = $bits(coeff_t);

endpackage

// File: rtl/mont_cond_sub.sv
// Combinational conditional subtract: brings a value in [0, 2Q) into [0, Q).
// Ports:
//   a_i - input value, assumed < 2Q
//   y_o - a_i - Q when a_i >= Q, otherwise a_i
module mont_cond_sub
  import ntt_pkg::*;
#(
  parameter int unsigned Q     = NEWHOPE_Q,
  parameter int unsigned OUT_W = COEFF_W
) (
  input  logic [OUT_W-1:0] a_i,
  output logic [OUT_W-1:0] y_o
);

  localparam logic [OUT_W-1:0] QW = OUT_W'(Q);

  always_comb begin
    y_o = (a_i >= QW) ? (a_i - QW) : a_i;
  end

endmodule

// File: rtl/montgomery_reduce_pipe.sv
// Fully pipelined Montgomery reduction: out = in * 2^-R_BITS mod Q.
// Valid/ready on both sides; one global advance enable stalls every stage together.
// Build option MONT_FINAL_SUB_EN: adds a registered conditional subtract so the result is
// fully reduced in [0, Q) with latency 3; without it the result is lazy in [0, 2Q), latency 2.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_data/in_tag      - value to reduce (must be < Q*2^R_BITS) and its sideband tag
//   in_valid/in_ready   - input handshake; in_ready is combinational from out_ready
//   out_data/out_tag    - reduced value and its tag
//   out_valid/out_ready - output handshake
module montgomery_reduce_pipe
  import ntt_pkg::*;
#(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned Q      = NEWHOPE_Q,
  parameter int unsigned QINV   = NEWHOPE_QINV,
  parameter int unsigned R_BITS = MONT_R_BITS,
  parameter int unsigned OUT_W  = COEFF_W,
  parameter int unsigned TAG_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  in_data,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [R_BITS-1:0] QinvR = R_BITS'(QINV);
  localparam logic [IN_W:0]     QExt  = (IN_W+1)'(Q);

  logic adv;

  logic [R_BITS-1:0] u1_d, u1_q;
  logic [IN_W-1:0]   d1_q;
  logic [TAG_W-1:0]  tag1_q;
  logic              v1_q;

  logic [IN_W:0]     t2;
  logic [OUT_W-1:0]  r2_d, r2_q;
  logic [TAG_W-1:0]  tag2_q;
  logic              v2_q;

  // A slot may move forward whenever the output register is empty or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Only the low R_BITS of the product matter, so the multiply is done at that width.
  always_comb begin
    u1_d = in_data[R_BITS-1:0] * QinvR;
  end

  // t = u*Q + d is divisible by 2^R_BITS; the extra bit absorbs the sum's carry.
  always_comb begin
    t2   = (IN_W+1)'(u1_q) * QExt + (IN_W+1)'(d1_q);
    r2_d = OUT_W'(t2 >> R_BITS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      u1_q   <= '0;
      d1_q   <= '0;
      tag1_q <= '0;
      v1_q   <= 1'b0;
      r2_q   <= '0;
      tag2_q <= '0;
      v2_q   <= 1'b0;
    end else if (adv) begin
      u1_q   <= u1_d;
      d1_q   <= in_data;
      tag1_q <= in_tag;
      v1_q   <= in_valid;
      r2_q   <= r2_d;
      tag2_q <= tag1_q;
      v2_q   <= v1_q;
    end
  end

`ifdef MONT_FINAL_SUB_EN
  logic [OUT_W-1:0] sub_y;
  logic [OUT_W-1:0] d3_q;
  logic [TAG_W-1:0] tag3_q;
  logic             v3_q;

  mont_cond_sub #(
    .Q     (Q),
    .OUT_W (OUT_W)
  ) u_cond_sub (
    .a_i (r2_q),
    .y_o (sub_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d3_q   <= '0;
      tag3_q <= '0;
      v3_q   <= 1'b0;
    end else if (adv) begin
      d3_q   <= sub_y;
      tag3_q <= tag2_q;
      v3_q   <= v2_q;
    end
  end

  assign out_data  = d3_q;
  assign out_tag   = tag3_q;
  assign out_valid = v3_q;
`else
  assign out_data  = r2_q;
  assign out_tag   = tag2_q;
  assign out_valid = v2_q;
`endif

`ifndef SYNTHESIS
  localparam logic [63:0] QQinvP1 = 64'(Q) * 64'(QINV) + 64'd1;
  localparam logic [63:0] RMask   = (64'd1 << R_BITS) - 64'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (Q % 2 == 1) else $error("Q must be odd");
      assert ((QQinvP1 & RMask) == 64'd0) else $error("QINV is not -Q^-1 mod 2^R_BITS");
      assert ((64'd1 << OUT_W) > 64'(2 * Q)) else $error("OUT_W too narrow for 2Q");
      assert (TAG_W >= 1) else $error("TAG_W must be at least 1");
      assert (R_BITS <= IN_W) else $error("R_BITS must not exceed IN_W");
    end
  end
`endif

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
module tb_montgomery_reduce_pipe;

  localparam int unsigned Q  = 12289;
  localparam int unsigned RB = 18;
`ifdef MONT_FINAL_SUB_EN
  localparam int LAT  = 3;
  localparam bit FULL = 1'b1;
`else
  localparam int LAT  = 2;
  localparam bit FULL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_data;
  logic [7:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [7:0]  out_tag;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  montgomery_reduce_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [15:0] exp;
    bit          exact;  // lazy build may also return exp + Q unless exact
    logic [7:0]  tag;
    int          issue;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   lat_mode = 1'b0;
  bit   stall_prev = 1'b0;
  bit   bub_done = 1'b0;
  logic [15:0] held_data;
  logic [7:0]  held_tag;
  logic [7:0]  tag_ctr = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Divide by 2 modulo Q, RB times: independent of the Montgomery datapath.
  function automatic logic [15:0] mont_ref(logic [31:0] x);
    logic [31:0] v;
    v = x % Q;
    for (int i = 0; i < RB; i++) v = v[0] ? ((v + Q) >> 1) : (v >> 1);
    return v[15:0];
  endfunction

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (!reset) begin
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_data_held", out_data, held_data);
        check("stall_tag_held", out_tag, held_tag);
      end
      if (out_valid && !out_ready) check("in_ready_low_when_stalled", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got data %0d tag %0d, expected no output",
                   out_data, out_tag);
        end else begin
          e = sb.pop_front();
          check("out_tag", out_tag, e.tag);
          ok = (out_data == e.exp) || (!e.exact && (out_data == e.exp + 16'(Q)));
          n_cmp++;
          if (!ok) begin
            n_bad++;
            $display("FAIL out_data tag %0d: got %0d, expected %0d%s", e.tag, out_data, e.exp,
                     e.exact ? "" : " (or +Q)");
          end
          if (e.chk_lat) check("latency", 64'(cyc - e.issue), 64'(LAT));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_tag   = out_tag;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [7:0] t, input logic [15:0] exp,
                      input bit exact, input bit track);
    int issue = 0;
    bit done = 1'b0;
    in_data  = d;
    in_tag   = t;
    in_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      issue = cyc;
      done  = in_ready;
      @(posedge clk);
    end
    #1;
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout tag %0d: got no in_ready, expected acceptance", t);
    end else if (track) begin
      sb.push_back('{exp: exp, exact: exact, tag: t, issue: issue, chk_lat: lat_mode});
    end
  endtask

  task automatic send_rand(input bit track);
    logic [31:0] r;
    r = $urandom_range(0, 32'd3221487615);  // Q*2^18 - 1
    tag_ctr = tag_ctr + 8'd1;
    send(r, tag_ctr, mont_ref(r), FULL, track);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int k = 0; k < 300 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_tag", out_tag, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic exact values with latency check.
    lat_mode = 1'b1;
    send(32'd0, 8'd1, 16'd0, 1'b1, 1'b1);
    send(32'd262144, 8'd2, 16'd1, 1'b1, 1'b1);
    send(32'd1310720, 8'd3, 16'd5, 1'b1, 1'b1);
    idle(2);
    drain();

    // Modulus boundary: u = 2^18-1, t = Q*2^18.
    send(32'd12289, 8'd4, FULL ? 16'd0 : 16'd12289, 1'b1, 1'b1);
    // Largest legal input: Q*2^18 - 1.
    send(32'd3221487615, 8'd5, mont_ref(32'd3221487615), FULL, 1'b1);
    drain();

    // Back-to-back random stream; latency check implies one result per cycle.
    for (int i = 0; i < 10000; i++) send_rand(1'b1);
    drain();
    lat_mode = 1'b0;

    // Backpressure: out_ready low for 5 cycles mid-stream.
    fork
      for (int i = 0; i < 30; i++) send_rand(1'b1);
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles with random downstream readiness.
    bub_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand(1'b1);
          idle(1);
        end
        bub_done = 1'b1;
      end
      begin
        for (int k = 0; k < 2000 && !bub_done; k++) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two samples in flight; they must never appear.
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'd1835008, 8'd90, 16'd7, 1'b1, 1'b0);
    send(32'd2097152, 8'd91, 16'd8, 1'b1, 1'b0);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    check("flush_out_tag", out_tag, 0);
    check("flush_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    idle(6);
    lat_mode = 1'b1;
    send(32'd262144, 8'd92, 16'd1, 1'b1, 1'b1);
    drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/montgomery_reduce_pipe.md
Name: montgomery_reduce_pipe

Overview:
- Parametrised, fully pipelined Montgomery reduction unit for the NTT datapath (butterfly multiplier output to coefficient memory).
- Computes out = in * 2^-R_BITS mod Q, with a valid/ready handshake on both sides and a sideband tag carried alongside each sample.
- Replaces the fixed 12289/18-bit, en/load-driven reducer.
- Accepts one sample per cycle when unstalled; stalls cleanly under downstream backpressure.

Parameters:
- IN_W, 32: input width; precondition in < Q*2^R_BITS.
- Q, 12289: odd modulus.
- QINV, 12287: -Q^-1 mod 2^R_BITS.
- R_BITS, 18: Montgomery radix exponent.
- OUT_W, 16: output width; must satisfy 2^OUT_W > 2*Q.
- TAG_W, 8: sideband tag width (address/index); >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- in_data, input, IN_W: value to reduce.
- in_tag, input, TAG_W: sideband, passed through unchanged.
- in_valid, input, 1: in_data/in_tag valid.
- in_ready, output, 1: unit accepts input this cycle.
- out_data, output, OUT_W: reduced value.
- out_tag, output, TAG_W: tag of out_data.
- out_valid, output, 1: out_data/out_tag valid.
- out_ready, input, 1: downstream accepts output.

Behaviour:
- Global pipeline advance: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready; permitted). A transfer occurs on in_valid && in_ready.
- Stage 1 (on adv):
  - u1 = (in_data * QINV) mod 2^R_BITS (R_BITS wide).
  - d1 = in_data.
  - tag1 = in_tag.
  - v1 = in_valid.
- Stage 2 (on adv):
  - t = u1*Q + d1, computed in IN_W+1 bits with no overflow.
  - r2 = t >> R_BITS, truncated to OUT_W; guaranteed < 2Q.
  - Tag and valid shift along with the data.
- Output stage: see Optional Feature. Latency from input transfer to out_valid is 2 cycles without the feature and 3 with it, absent stalls.
- Stall: when !adv, every data, tag and valid register holds. out_data/out_tag stay stable while out_valid && !out_ready. No sample is dropped or duplicated.
- Bubbles: invalid slots propagate with valid=0. Data registers may load garbage in invalid slots, but out_data is only meaningful when out_valid=1.
- Throughput: 1 sample/cycle with out_ready held high. Ordering is strictly FIFO.
- Reset:
  - All valid bits clear to 0, so out_valid=0 the cycle after reset.
  - out_data and out_tag reset to 0.
  - in_ready=1 after reset, since out_valid=0.
  - Reset mid-operation discards in-flight samples; no partial output appears.
- Simultaneous reset and in_valid: reset wins and the input is not captured.
- Precondition violation (in_data >= Q*2^R_BITS): result is undefined but the handshake remains correct. The bench does not check it.
- Multiplies are expected to infer DSPs. Parameter-legality assertions go in simulation-only code.

Optional Feature:
- Macro: MONT_FINAL_SUB_EN.
- Defined:
  - Adds a third registered stage computing out = (r2 >= Q) ? r2 - Q : r2.
  - out_data is fully reduced in [0, Q). Latency 3.
- Undefined:
  - out_data = r2, a lazy result in [0, 2Q). Latency 2.
  - No third register stage.
- Handshake, stall and reset rules are identical in both builds.

Decomposition:
- Shared package ntt_pkg holds:
  - NEWHOPE_Q = 12289
  - NEWHOPE_QINV = 12287
  - MONT_R_BITS = 18
  - Coefficient typedef coeff_t (16 bits)
- The module defaults its parameters from ntt_pkg.
- One natural sub-module: mont_cond_sub, the combinational conditional subtract parametrised on Q/OUT_W, which is reusable in the Barrett/add units. It is instantiated only under MONT_FINAL_SUB_EN.

Test Plan:
- Basic values, out_ready=1: in_data=0, 262144 (2^18), 5*262144 with tags 1,2,3 -> out_data 0, 1, 5, tags 1,2,3. Each appears exactly LAT cycles after its transfer.
- Modulus boundary: in_data=12289 -> out_data 0 with MONT_FINAL_SUB_EN, 12289 without. This exercises u=2^18-1 and t=Q*2^18.
- Streaming and range: 10,000 random in_data < 12289*2^18, back-to-back.
  - Results match the reference model in*2^-18 mod Q, allowing +Q in the lazy build.
  - Output is < Q (feature on) or < 2Q (feature off).
  - One result per cycle.
- Backpressure: hold out_ready=0 for 5 cycles while streaming.
  - in_ready drops once out_valid=1.
  - out_data/out_tag stay stable.
  - After release, the sequence resumes with no loss or duplication.
- Bubbles: alternate in_valid 1/0 with random out_ready -> output order and tags preserved, and out_valid never asserts for bubble slots.
- Reset mid-stream: assert reset for 1 cycle with 2 samples in flight.
  - Next cycle out_valid=0, out_data=0, in_ready=1.
  - The flushed samples never appear.
  - A new sample in_data=262144 then returns 1.
